// File: rtl/inv_sqrt_nr.sv
// Fixed-point reciprocal square root: normalise x into [1,4), take a table seed,
// refine it with Newton-Raphson on one shared multiplier, then denormalise with saturation.
module inv_sqrt_nr #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 24,
   parameter int LUT_BITS = 8,
   parameter int NR_ITERS = 1,
   parameter int TAG_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero,
   output logic             out_sat
);
   localparam int PW    = $clog2(WIDTH);
   localparam int KW    = PW + 1;
   localparam int LUT_N = 2 ** LUT_BITS;
   localparam logic [1:0]       ITER_LAST = 2'(NR_ITERS - 1);
   localparam logic [WIDTH-1:0] THREE     = {{(WIDTH-2){1'b0}}, 2'b11} << FRAC;
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

   typedef enum logic [2:0] {IDLE, NORM, SEED, NR, DENORM, HOLD} state_t;

   // Bins split [0,4) evenly; entry = round(1/sqrt(midpoint)) in Q1.FRAC, clamped below 2.
   function automatic logic [WIDTH-1:0] seed_val(input int idx);
      logic [127:0] num;
      logic [127:0] root;
      logic [127:0] trial;
      logic [127:0] max_v;
      num   = (128'd1 << (2*FRAC + LUT_BITS + 1)) / 128'(2*idx + 1);
      root  = 128'd0;
      max_v = (128'd1 << (FRAC + 1)) - 128'd1;
      for (int b = 60; b >= 0; b--) begin
         trial = root | (128'd1 << b);
         if (trial * trial <= num) root = trial;
      end
      root = (root + 128'd1) >> 1;
      if (root > max_v) root = max_v;
      return WIDTH'(root);
   endfunction

   logic [WIDTH-1:0] seed_lut [LUT_N];
   for (genvar i = 0; i < LUT_N; i++) begin : g_lut
      localparam logic [WIDTH-1:0] SEED_I = seed_val(i);
      assign seed_lut[i] = SEED_I;
   end

   state_t                 state_r, next_state_s;
   logic [WIDTH-1:0]       x_r, m_r, y_r, t_r, res_r, m_s, a_s, b_s, three_m_s, shr_s;
   logic [TAG_W-1:0]       tag_r;
   logic                   zero_r, sat_r, ovf_s;
   logic signed [KW-1:0]   k_r, k_s;
   logic [KW-1:0]          kmag_s;
   logic [1:0]             sub_r, iter_r;
   logic [PW-1:0]          lead_s;
   logic [2*WIDTH-1:0]     prod_s, wide_s;
   int                     d_s, sh_s;

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:   if (in_valid && in_ready) next_state_s = NORM; else next_state_s = IDLE;
         NORM:   next_state_s = SEED;
         SEED:   if (NR_ITERS == 0) next_state_s = DENORM; else next_state_s = NR;
         NR:     if (sub_r == 2'd2 && iter_r == ITER_LAST) next_state_s = DENORM;
                 else next_state_s = NR;
         DENORM: next_state_s = HOLD;
         HOLD:   if (out_valid && out_ready) next_state_s = IDLE; else next_state_s = HOLD;
         default: next_state_s = IDLE;
      endcase
   end

   // Leading-one search and even normalising shift (m in [1,4), k = shift/2).
   always_comb begin
      lead_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (x_r[i]) lead_s = PW'(i);
         else lead_s = lead_s;
      end
      d_s  = int'(lead_s) - FRAC;
      sh_s = d_s - (d_s & 1);
      k_s  = KW'(sh_s >>> 1);
      if (sh_s >= 0) m_s = x_r >> sh_s;
      else m_s = x_r << (-sh_s);
   end

   // Shared multiplier operand select for the three Newton-Raphson sub-steps.
   always_comb begin
      a_s = '0;
      b_s = '0;
      if (t_r > THREE) three_m_s = '0;
      else three_m_s = THREE - t_r;
      case (sub_r)
         2'd0:    begin a_s = y_r; b_s = y_r;       end
         2'd1:    begin a_s = m_r; b_s = t_r;       end
         2'd2:    begin a_s = y_r; b_s = three_m_s; end
         default: begin a_s = '0;  b_s = '0;        end
      endcase
      prod_s = (2*WIDTH)'(a_s) * (2*WIDTH)'(b_s);
   end

   // Denormalisation shift with overflow detection on left shifts.
   always_comb begin
      if (k_r[KW-1]) kmag_s = -k_r;
      else kmag_s = k_r;
      wide_s = (2*WIDTH)'(y_r) << kmag_s;
      shr_s  = y_r >> kmag_s;
      ovf_s  = k_r[KW-1] && (|wide_s[2*WIDTH-1:WIDTH]);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         in_ready  <= 1'b0;
         x_r       <= '0;
         tag_r     <= '0;
         zero_r    <= 1'b0;
         m_r       <= '0;
         k_r       <= '0;
         y_r       <= '0;
         t_r       <= '0;
         sub_r     <= 2'd0;
         iter_r    <= 2'd0;
         res_r     <= '0;
         sat_r     <= 1'b0;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_tag   <= '0;
         out_zero  <= 1'b0;
         out_sat   <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         in_ready <= (next_state_s == IDLE);
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_r    <= in_x;
                  tag_r  <= in_tag;
                  zero_r <= (in_x == '0);
               end
            end
            NORM: begin
               m_r <= m_s;
               k_r <= k_s;
            end
            SEED: begin
               y_r    <= seed_lut[m_r[FRAC+1 -: LUT_BITS]];
               sub_r  <= 2'd0;
               iter_r <= 2'd0;
            end
            NR: begin
               case (sub_r)
                  2'd0:    begin t_r <= WIDTH'(prod_s >> FRAC); sub_r <= 2'd1; end
                  2'd1:    begin t_r <= WIDTH'(prod_s >> FRAC); sub_r <= 2'd2; end
                  2'd2:    begin
                     y_r    <= WIDTH'(prod_s >> (FRAC + 1));
                     sub_r  <= 2'd0;
                     iter_r <= iter_r + 2'd1;
                  end
                  default: sub_r <= 2'd0;
               endcase
            end
            DENORM: begin
               if (zero_r || ovf_s) res_r <= ALL_ONES;
               else if (k_r[KW-1]) res_r <= wide_s[WIDTH-1:0];
               else res_r <= shr_s;
               sat_r <= zero_r || ovf_s;
            end
            HOLD: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_y     <= res_r;
                  out_tag   <= tag_r;
                  out_zero  <= zero_r;
                  out_sat   <= sat_r;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inv_sqrt_nr.sv
// Self-checking bench for inv_sqrt_nr: three instances (NR_ITERS 0,1,2) driven in lockstep,
// results compared against real-arithmetic 1/sqrt(x) with iteration-dependent tolerance.
module tb_inv_sqrt_nr;
   localparam int N = 3;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid [N];
   logic        in_ready [N];
   logic [31:0] in_x     [N];
   logic [3:0]  in_tag   [N];
   logic        out_valid[N];
   logic        out_ready[N];
   logic [31:0] out_y    [N];
   logic [3:0]  out_tag  [N];
   logic        out_zero [N];
   logic        out_sat  [N];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      inv_sqrt_nr #(.NR_ITERS(g)) dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_x(in_x[g]), .in_tag(in_tag[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]),
         .out_y(out_y[g]), .out_tag(out_tag[g]),
         .out_zero(out_zero[g]), .out_sat(out_sat[g])
      );
   end

   task automatic check(input string tag, input int u, input longint got, input longint exp,
                        input longint tol);
      longint diff;
      n_cmp++;
      diff = got - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_bad++;
         $display("FAIL %s[nr%0d]: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                  tag, u, got, got, exp, exp, tol);
      end
   endtask

   // Reference: y = 2^FRAC / sqrt(x / 2^FRAC) = 2^36 / sqrt(x) for Q8.24.
   task automatic check_result(input int u, input logic [31:0] x, input logic [31:0] y,
                               input logic z, input logic s);
      real r, rel;
      if (x == 32'd0) begin
         check("zero_y", u, y, ONES, 0);
         check("zero_flag", u, z, 1, 0);
         check("zero_sat", u, s, 1, 0);
      end else begin
         r   = 68719476736.0 / $sqrt(real'(x));
         rel = (u == 0) ? 1.0 / 128.0 : 1.0 / 16384.0;
         check("nz_flag", u, z, 0, 0);
         if (r > 4294967296.0 * (1.0 + 2.0 * rel)) begin
            check("sat_flag", u, s, 1, 0);
            check("sat_y", u, y, ONES, 0);
         end else if (r < 4294967295.0 * (1.0 - 2.0 * rel)) begin
            check("nosat_flag", u, s, 0, 0);
            check("accuracy", u, y, longint'(r), longint'(rel * r) + 2);
         end else begin
            check("sat_consistent", u, (s && y != ONES) ? 1 : 0, 0, 0);
         end
      end
   endtask

   task automatic do_op(input int u, input logic [31:0] x, input logic [3:0] tag,
                        input int stall);
      int          lat;
      logic [31:0] y0;
      logic [3:0]  t0;
      logic        z0, s0;
      for (int i = 0; i < 20 && in_ready[u] !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      check("in_ready_idle", u, in_ready[u], 1, 0);
      in_valid[u] = 1'b1;
      in_x[u]     = x;
      in_tag[u]   = tag;
      @(posedge clk); #1;
      in_valid[u] = 1'b0;
      in_x[u]     = $urandom;
      in_tag[u]   = 4'($urandom);
      check("in_ready_busy", u, in_ready[u], 0, 0);
      lat = 0;
      while (out_valid[u] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", u, lat, 4 + 3 * u, 0);
      y0 = out_y[u]; t0 = out_tag[u]; z0 = out_zero[u]; s0 = out_sat[u];
      check("tag", u, t0, tag, 0);
      check_result(u, x, y0, z0, s0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("hold_valid", u, out_valid[u], 1, 0);
         check("hold_y", u, out_y[u], y0, 0);
         check("hold_flags", u, {out_tag[u], out_zero[u], out_sat[u]}, {t0, z0, s0}, 0);
         check("hold_in_ready", u, in_ready[u], 0, 0);
      end
      out_ready[u] = 1'b1;
      @(posedge clk); #1;
      out_ready[u] = 1'b0;
      check("valid_drop", u, out_valid[u], 0, 0);
      check("ready_back", u, in_ready[u], 1, 0);
   endtask

   task automatic all_op(input logic [31:0] x, input logic [3:0] tag, input int stall);
      fork
         do_op(0, x, tag, stall);
         do_op(1, x, tag, stall);
         do_op(2, x, tag, stall);
      join
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst = 1'b1;
      for (int u = 0; u < N; u++) begin
         in_valid[u] = 1'b0; out_ready[u] = 1'b0; in_x[u] = 32'd0; in_tag[u] = 4'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < N; u++) begin
         check("rst_in_ready", u, in_ready[u], 0, 0);
         check("rst_out_valid", u, out_valid[u], 0, 0);
         check("rst_out_y", u, out_y[u], 0, 0);
         check("rst_flags", u, {out_tag[u], out_zero[u], out_sat[u]}, 0, 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int u = 0; u < N; u++) check("post_rst_ready", u, in_ready[u], 1, 0);

      all_op(32'h0100_0000, 4'd3, 0);
      all_op(32'h0400_0000, 4'd5, 0);
      all_op(32'h0040_0000, 4'd6, 0);
      all_op(32'h0000_0001, 4'd7, 0);
      all_op(32'h0000_0000, 4'd8, 0);
      all_op(32'hFFFF_FFFF, 4'd9, 0);
      all_op(32'h0100_0000, 4'd10, 5);

      // Reset three edges after an accept must abandon the operation.
      for (int u = 0; u < N; u++) begin
         in_valid[u] = 1'b1; in_x[u] = 32'h0100_0000; in_tag[u] = 4'd11;
      end
      @(posedge clk); #1;
      for (int u = 0; u < N; u++) in_valid[u] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int u = 0; u < N; u++) begin
         check("midrst_ready", u, in_ready[u], 0, 0);
         check("midrst_valid", u, out_valid[u], 0, 0);
      end
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         for (int u = 0; u < N; u++) if (out_valid[u] !== 1'b0) seen++;
      end
      check("rst_abandon", 0, seen, 0, 0);
      all_op(32'h0400_0000, 4'd12, 0);

      for (int i = 0; i < 1500; i++) begin
         all_op($urandom >> $urandom_range(0, 31), 4'(i), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
